// File: rtl/psdram_arbiter.sv
// psdram_arbiter
// Shares the single PSDRAM port between the VGA line-fetch reader and the
// frame-loader writer. Sequences CE, OE/WR strobes, byte lanes, bus drive and
// recovery time for every access.
// The strobes, MemAdr and the bus-drive enable come straight from flops, so
// the pins never glitch.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no access; arbitration between rd_req and wr_req
// RD_ACC    | read strobe phase, MemOE/RamCE/lanes low for ACCESS_CYCLES
// WR_ACC    | write phase, MemWR low for ACCESS_CYCLES-1, then data hold
// RECOVER   | CE high for RECOVER_CYCLES before the next arbitration
module psdram_arbiter #(
  parameter int ACCESS_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 1,
  parameter int MAX_WR_STARVE  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [22:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  input  logic        wr_req,
  input  logic [22:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic        wr_gnt,
  output logic        wr_done,
  output logic        busy,
  output logic [22:0] MemAdr,
  output logic        MemOE,
  output logic        MemWR,
  output logic        RamCE,
  output logic        RamLB,
  output logic        RamUB,
  input  logic [15:0] MemDataIn,
  output logic [15:0] MemDataOut,
  output logic        MemDataOE
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_ACC  = 2'd1;
  localparam logic [1:0] S_WR_ACC  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  // Counter compare points; the access counter is reused during recovery.
  localparam logic [3:0] ACC_LAST   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] ACC_WR_END = 4'(ACCESS_CYCLES - 2);
  localparam logic [3:0] REC_LAST   = 4'(RECOVER_CYCLES - 1);
  localparam logic [7:0] STARVE_MAX = 8'(MAX_WR_STARVE);
  localparam bit         NO_RECOVER = (RECOVER_CYCLES == 0);

  logic [1:0] state;
  logic [3:0] acc_cnt;
  logic [7:0] starve_cnt;

  logic idle;
  logic in_access;
  logic write_wins;
  logic grant_rd;
  logic grant_wr;
  logic acc_last;
  logic wr_strobe_end;
  logic rec_last;

  // Arbitration and phase-end decodes shared by all the registers below.
  always_comb begin
    idle          = (state == S_IDLE);
    in_access     = (state == S_RD_ACC) || (state == S_WR_ACC);
    // A starved writer only overrides a competing read once the limit is hit.
    write_wins    = wr_req && (!rd_req || (starve_cnt == STARVE_MAX));
    grant_wr      = idle && write_wins;
    grant_rd      = idle && rd_req && !write_wins;
    acc_last      = in_access && (acc_cnt == ACC_LAST);
    wr_strobe_end = (state == S_WR_ACC) && (acc_cnt == ACC_WR_END);
    rec_last      = (state == S_RECOVER) && (acc_cnt == REC_LAST);
  end

  assign busy = !idle;

  // Sequencer: state plus the access/recovery cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      acc_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          acc_cnt <= '0;
          if (grant_rd) begin
            state <= S_RD_ACC;
          end else if (grant_wr) begin
            state <= S_WR_ACC;
          end
        end
        S_RD_ACC, S_WR_ACC: begin
          if (acc_last) begin
            acc_cnt <= '0;
            state   <= NO_RECOVER ? S_IDLE : S_RECOVER;
          end else begin
            acc_cnt <= acc_cnt + 4'd1;
          end
        end
        S_RECOVER: begin
          if (rec_last) begin
            acc_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            acc_cnt <= acc_cnt + 4'd1;
          end
        end
        default: begin
          acc_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Write-starvation counter: counts reads granted over a waiting writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!wr_req || grant_wr) begin
      starve_cnt <= '0;
    end else if (grant_rd && (starve_cnt != 8'hFF)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Address, write data and read data capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      MemAdr     <= '0;
      MemDataOut <= '0;
      rd_data    <= '0;
    end else begin
      if (grant_rd) begin
        MemAdr <= rd_addr;
      end else if (grant_wr) begin
        MemAdr     <= wr_addr;
        MemDataOut <= wr_data;
      end
      if (acc_last && (state == S_RD_ACC)) begin
        rd_data <= MemDataIn;
      end
    end
  end

  // PSDRAM strobes and bus-drive enable, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      RamCE     <= 1'b1;
      MemOE     <= 1'b1;
      MemWR     <= 1'b1;
      RamLB     <= 1'b1;
      RamUB     <= 1'b1;
      MemDataOE <= 1'b0;
    end else if (grant_rd) begin
      RamCE     <= 1'b0;
      MemOE     <= 1'b0;
      MemWR     <= 1'b1;
      RamLB     <= 1'b0;
      RamUB     <= 1'b0;
      MemDataOE <= 1'b0;
    end else if (grant_wr) begin
      RamCE     <= 1'b0;
      MemOE     <= 1'b1;
      MemWR     <= 1'b0;
      RamLB     <= ~wr_be[0];
      RamUB     <= ~wr_be[1];
      MemDataOE <= 1'b1;
    end else if (acc_last || (state == S_RECOVER)) begin
      RamCE     <= 1'b1;
      MemOE     <= 1'b1;
      MemWR     <= 1'b1;
      RamLB     <= 1'b1;
      RamUB     <= 1'b1;
      MemDataOE <= 1'b0;
    end else if (wr_strobe_end) begin
      // WR rises one cycle early so the bus is still driven for data hold.
      MemWR <= 1'b1;
    end
  end

  // One-cycle handshake pulses back to the requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_gnt   <= 1'b0;
      wr_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      rd_gnt   <= grant_rd;
      wr_gnt   <= grant_wr;
      rd_valid <= acc_last && (state == S_RD_ACC);
      wr_done  <= acc_last && (state == S_WR_ACC);
    end
  end

endmodule

// File: tb/tb_psdram_arbiter.sv
// Testbench for psdram_arbiter: three instances (defaults, MAX_WR_STARVE=2,
// ACCESS_CYCLES=2/RECOVER_CYCLES=0) share the requester stimulus.
module tb_psdram_arbiter;

  localparam int A    = 4;
  localparam int R    = 1;
  localparam int MAXS = 8;
  // {rd_gnt, wr_gnt, rd_valid, wr_done, busy, CE, OE, WR, LB, UB, DataOE}
  localparam logic [10:0] IDLE_STS = 11'b00000_11111_0;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        rd_req  = 1'b0;
  logic [22:0] rd_addr = '0;
  logic        wr_req  = 1'b0;
  logic [22:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be   = '0;
  logic [15:0] md_in   = '0;

  logic [2:0]  rd_gnt, rd_valid, wr_gnt, wr_done, busy;
  logic [2:0]  mem_oe, mem_wr, ram_ce, ram_lb, ram_ub, mem_doe;
  logic [15:0] rd_data  [3];
  logic [22:0] mem_adr  [3];
  logic [15:0] mem_dout [3];

  int vectors     = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  psdram_arbiter u_def (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_gnt(wr_gnt[0]), .wr_done(wr_done[0]), .busy(busy[0]),
    .MemAdr(mem_adr[0]), .MemOE(mem_oe[0]), .MemWR(mem_wr[0]), .RamCE(ram_ce[0]),
    .RamLB(ram_lb[0]), .RamUB(ram_ub[0]),
    .MemDataIn(md_in), .MemDataOut(mem_dout[0]), .MemDataOE(mem_doe[0])
  );

  psdram_arbiter #(.MAX_WR_STARVE(2)) u_starve (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_gnt(wr_gnt[1]), .wr_done(wr_done[1]), .busy(busy[1]),
    .MemAdr(mem_adr[1]), .MemOE(mem_oe[1]), .MemWR(mem_wr[1]), .RamCE(ram_ce[1]),
    .RamLB(ram_lb[1]), .RamUB(ram_ub[1]),
    .MemDataIn(md_in), .MemDataOut(mem_dout[1]), .MemDataOE(mem_doe[1])
  );

  psdram_arbiter #(.ACCESS_CYCLES(2), .RECOVER_CYCLES(0)) u_fast (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_gnt(wr_gnt[2]), .wr_done(wr_done[2]), .busy(busy[2]),
    .MemAdr(mem_adr[2]), .MemOE(mem_oe[2]), .MemWR(mem_wr[2]), .RamCE(ram_ce[2]),
    .RamLB(ram_lb[2]), .RamUB(ram_ub[2]),
    .MemDataIn(md_in), .MemDataOut(mem_dout[2]), .MemDataOE(mem_doe[2])
  );

  function automatic logic [10:0] sts(input int i);
    return {rd_gnt[i], wr_gnt[i], rd_valid[i], wr_done[i], busy[i],
            ram_ce[i], mem_oe[i], mem_wr[i], ram_lb[i], ram_ub[i], mem_doe[i]};
  endfunction

  // Reference model of the default instance, tracked as "age of the current
  // transaction" rather than as states: t counts cycles since the grant.
  typedef struct {
    bit          in_txn;
    int          t;
    bit          is_wr;
    logic [1:0]  be;
    int          starve;
    logic [15:0] rdat;
    logic [22:0] adr;
    logic [15:0] dout;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    bit idle_now, g_rd, g_wr;
    n = s;
    if (reset) begin
      n.in_txn = 0; n.t = 0; n.is_wr = 0; n.be = 0; n.starve = 0;
      n.rdat = 0; n.adr = 0; n.dout = 0;
      return n;
    end
    idle_now = !s.in_txn || (s.t >= A + R);
    if (s.in_txn && !s.is_wr && s.t == A - 1) n.rdat = md_in;
    g_rd = 0; g_wr = 0;
    if (idle_now) begin
      if (wr_req && (!rd_req || s.starve == MAXS)) g_wr = 1;
      else if (rd_req) g_rd = 1;
    end
    if (!wr_req || g_wr) n.starve = 0;
    else if (g_rd && s.starve < 255) n.starve = s.starve + 1;
    if (g_rd || g_wr) begin
      n.in_txn = 1; n.t = 0; n.is_wr = g_wr;
      n.adr = g_wr ? wr_addr : rd_addr;
      if (g_wr) begin n.dout = wr_data; n.be = wr_be; end
    end else if (s.in_txn) begin
      if (s.t >= A + R) n.in_txn = 0;
      else n.t = s.t + 1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  function automatic logic [10:0] model_sts();
    bit acc;
    acc = m.in_txn && (m.t < A);
    return {m.in_txn && !m.is_wr && m.t == 0, m.in_txn && m.is_wr && m.t == 0,
            m.in_txn && !m.is_wr && m.t == A, m.in_txn && m.is_wr && m.t == A,
            m.in_txn && (m.t < A + R), !acc, !(acc && !m.is_wr),
            !(acc && m.is_wr && m.t <= A - 2),
            !(acc && (!m.is_wr || m.be[0])), !(acc && (!m.is_wr || m.be[1])),
            acc && m.is_wr};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1; rd_req = 0; wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; rd_req = 0; wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sts(i) !== IDLE_STS) begin
        miscompares++;
        $display("FAIL reset_sts inst=%0d got=%b want=%b", i, sts(i), IDLE_STS);
      end
      vectors++;
      if ({mem_adr[i], mem_dout[i], rd_data[i]} !== 55'd0) begin
        miscompares++;
        $display("FAIL reset_regs inst=%0d adr=%h dout=%h rdata=%h want 0", i, mem_adr[i], mem_dout[i], rd_data[i]);
      end
    end
    reset = 0;
  endtask

  task automatic test_single_read();
    logic [10:0] exp;
    bit lo;
    do_reset();
    md_in = 16'hA5C3; rd_addr = 23'h012C0; rd_req = 1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      lo  = (c <= 3) || (c == 6);
      exp = {c == 0 || c == 6, 1'b0, c == 4, 1'b0, c != 5, !lo, !lo, 1'b1, !lo, !lo, 1'b0};
      vectors++;
      if (sts(0) !== exp) begin
        miscompares++;
        $display("FAIL rd_single_sts c=%0d got=%b want=%b", c, sts(0), exp);
      end
      if (c == 0) begin
        vectors++;
        if (mem_adr[0] !== 23'h012C0) begin
          miscompares++;
          $display("FAIL rd_single_adr got=%h want=012c0", mem_adr[0]);
        end
      end
      if (c == 4) begin
        vectors++;
        if (rd_data[0] !== 16'hA5C3) begin
          miscompares++;
          $display("FAIL rd_single_data got=%h want=a5c3", rd_data[0]);
        end
      end
    end
    rd_req = 0;
  endtask

  task automatic test_single_write();
    logic [10:0] exp;
    do_reset();
    wr_addr = 23'h7FFFFF; wr_data = 16'h1234; wr_be = 2'b10; wr_req = 1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp = {1'b0, c == 0, 1'b0, c == 4, c <= 4, !(c <= 3), 1'b1, !(c <= 2), 1'b1, !(c <= 3), c <= 3};
      vectors++;
      if (sts(0) !== exp) begin
        miscompares++;
        $display("FAIL wr_single_sts c=%0d got=%b want=%b", c, sts(0), exp);
      end
      if (c == 0) begin
        vectors++;
        if ({mem_adr[0], mem_dout[0]} !== {23'h7FFFFF, 16'h1234}) begin
          miscompares++;
          $display("FAIL wr_single_adr_data got=%h/%h want=7fffff/1234", mem_adr[0], mem_dout[0]);
        end
        wr_req = 0;
      end
    end
  endtask

  task automatic test_starvation();
    int  g_cyc[$];
    bit  g_wr[$];
    do_reset();
    rd_req = 1; wr_req = 1; wr_be = 2'b11;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rd_gnt[1] || wr_gnt[1]) begin
        g_cyc.push_back(c);
        g_wr.push_back(wr_gnt[1]);
      end
    end
    rd_req = 0; wr_req = 0;
    vectors++;
    if (g_cyc.size() != 10) begin
      miscompares++;
      $display("FAIL starve_count got=%0d want=10", g_cyc.size());
    end
    for (int k = 0; k < g_cyc.size(); k++) begin
      vectors++;
      if (g_wr[k] !== (k % 3 == 2) || g_cyc[k] != 6 * k) begin
        miscompares++;
        $display("FAIL starve_order k=%0d got wr=%0d cyc=%0d want wr=%0d cyc=%0d",
                 k, g_wr[k], g_cyc[k], (k % 3 == 2), 6 * k);
      end
    end
  endtask

  task automatic test_rd_drop();
    logic [10:0] exp;
    do_reset();
    wr_addr = 23'($urandom); wr_data = 16'($urandom); wr_be = 2'b00; wr_req = 1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      exp = {1'b0, c == 0, 1'b0, c == 4, c <= 4, !(c <= 3), 1'b1, !(c <= 2), 1'b1, 1'b1, c <= 3};
      vectors++;
      if (sts(0) !== exp) begin
        miscompares++;
        $display("FAIL rd_drop_sts c=%0d got=%b want=%b", c, sts(0), exp);
      end
      if (c == 0) wr_req = 0;
      if (c == 1) begin rd_req = 1; rd_addr = 23'($urandom); end
      if (c == 4) rd_req = 0;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [10:0] exp;
    logic [15:0] dword;
    logic [22:0] raddr;
    int g, v;
    do_reset();
    wr_addr = 23'($urandom); wr_data = 16'($urandom); wr_be = 2'b11; wr_req = 1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      exp = {1'b0, c == 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, !(c <= 2), 1'b0, 1'b0, 1'b1};
      vectors++;
      if (sts(0) !== exp) begin
        miscompares++;
        $display("FAIL rst_mid_pre c=%0d got=%b want=%b", c, sts(0), exp);
      end
      if (c == 0) wr_req = 0;
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    vectors++;
    if (sts(0) !== IDLE_STS || mem_adr[0] !== 23'd0) begin
      miscompares++;
      $display("FAIL rst_mid_abort got=%b adr=%h want=%b adr=0", sts(0), mem_adr[0], IDLE_STS);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (sts(0) !== IDLE_STS) begin
        miscompares++;
        $display("FAIL rst_mid_quiet c=%0d got=%b want=%b", c, sts(0), IDLE_STS);
      end
    end
    raddr = 23'($urandom); dword = 16'($urandom);
    rd_addr = raddr; md_in = dword; rd_req = 1;
    g = -1; v = -1;
    for (int c = 0; c < 20 && v < 0; c++) begin
      @(negedge clk);
      if (rd_gnt[0]) begin g = c; rd_req = 0; end
      if (rd_valid[0]) v = c;
    end
    rd_req = 0;
    vectors++;
    if (v < 0 || g < 0) begin
      miscompares++;
      $display("FAIL rst_mid_read timeout gnt=%0d valid=%0d want both seen", g, v);
    end else if (v - g != 4 || rd_data[0] !== dword || mem_adr[0] !== raddr) begin
      miscompares++;
      $display("FAIL rst_mid_read lat=%0d data=%h adr=%h want lat=4 data=%h adr=%h",
               v - g, rd_data[0], mem_adr[0], dword, raddr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [30];
    logic [4:0]  exp;
    do_reset();
    md_in = '0; rd_addr = 23'($urandom); rd_req = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      exp = {c % 3 == 0, c % 3 == 2, c % 3 == 2, c % 3 == 2, c % 3 != 2};
      vectors++;
      if ({rd_gnt[2], rd_valid[2], ram_ce[2], mem_oe[2], busy[2]} !== exp) begin
        miscompares++;
        $display("FAIL b2b_sts c=%0d got=%b want=%b", c, {rd_gnt[2], rd_valid[2], ram_ce[2], mem_oe[2], busy[2]}, exp);
      end
      if (c % 3 == 2) begin
        vectors++;
        if (rd_data[2] !== vals[c-1]) begin
          miscompares++;
          $display("FAIL b2b_data c=%0d got=%h want=%h", c, rd_data[2], vals[c-1]);
        end
      end
      vals[c] = 16'($urandom);
      md_in   = vals[c];
    end
    rd_req = 0;
  endtask

  task automatic test_random();
    logic [10:0] exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      exp = model_sts();
      vectors++;
      if (sts(0) !== exp) begin
        miscompares++;
        $display("FAIL rand_sts n=%0d got=%b want=%b", n, sts(0), exp);
      end
      vectors++;
      if (mem_adr[0] !== m.adr) begin
        miscompares++;
        $display("FAIL rand_adr n=%0d got=%h want=%h", n, mem_adr[0], m.adr);
      end
      vectors++;
      if (rd_data[0] !== m.rdat) begin
        miscompares++;
        $display("FAIL rand_rdata n=%0d got=%h want=%h", n, rd_data[0], m.rdat);
      end
      vectors++;
      if (mem_dout[0] !== m.dout) begin
        miscompares++;
        $display("FAIL rand_dout n=%0d got=%h want=%h", n, mem_dout[0], m.dout);
      end
      reset = ($urandom_range(0, 199) == 0);
      if (rd_gnt[0]) begin
        rd_req = ($urandom_range(0, 3) != 0); rd_addr = 23'($urandom);
      end else if (!rd_req) begin
        if ($urandom_range(0, 1) == 0) begin rd_req = 1; rd_addr = 23'($urandom); end
      end else if ($urandom_range(0, 19) == 0) begin
        rd_req = 0;
      end
      if (wr_gnt[0] || !wr_req) begin
        if (wr_gnt[0]) wr_req = ($urandom_range(0, 1) == 0);
        else wr_req = ($urandom_range(0, 3) == 0);
        wr_addr = 23'($urandom); wr_data = 16'($urandom); wr_be = 2'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        wr_req = 0;
      end
      md_in = 16'($urandom);
    end
    reset = 0; rd_req = 0; wr_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_starvation();
    test_rd_drop();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
